// File: rtl/alut_mem_arbiter.sv
// alut_mem_arbiter: owner-hold arbiter sharing the 256x83 ALUT memory between the address and age checkers.
// Optional build macro ALUT_ARB_CONFLICT_CNT_EN adds a saturating 16-bit arb_conflict_cnt output.
module alut_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 83
) (
    input  logic              pclk,
    input  logic              n_p_reset,
    input  logic              add_check_active,
    input  logic [ADDR_W-1:0] mem_addr_add,
    input  logic              mem_write_add,
    input  logic [DATA_W-1:0] mem_write_data_add,
    input  logic              age_check_active,
    input  logic [ADDR_W-1:0] mem_addr_age,
    input  logic              mem_write_age,
    input  logic [DATA_W-1:0] mem_write_data_age,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_cs,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [DATA_W-1:0] mem_read_data_add,
    output logic [DATA_W-1:0] mem_read_data_age,
`ifdef ALUT_ARB_CONFLICT_CNT_EN
    output logic [15:0]       arb_conflict_cnt,
`endif
    output logic              grant_add,
    output logic              grant_age
);
    typedef enum logic [1:0] {IDLE, ADD, AGE} owner_t;

    owner_t            owner;
    owner_t            nxt;
    owner_t            rd_tag;
    logic [DATA_W-1:0] hold_add;
    logic [DATA_W-1:0] hold_age;

    // Owner keeps the memory while active; otherwise add has priority, so handover costs no cycle
    always_comb
        nxt = ((owner == ADD && add_check_active) || (owner == AGE && age_check_active)) ? owner :
              add_check_active ? ADD : age_check_active ? AGE : IDLE;

    // Owner register with grants registered alongside it
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            owner     <= IDLE;
            grant_add <= 1'b0;
            grant_age <= 1'b0;
        end else begin
            owner     <= nxt;
            grant_add <= (nxt == ADD);
            grant_age <= (nxt == AGE);
        end
    end

    assign mem_cs         = (owner != IDLE);
    assign mem_addr       = (owner == ADD) ? mem_addr_add : (owner == AGE) ? mem_addr_age : '0;
    assign mem_write      = (owner == ADD) ? mem_write_add : (owner == AGE) && mem_write_age;
    assign mem_write_data = (owner == ADD) ? mem_write_data_add :
                            (owner == AGE) ? mem_write_data_age : '0;

    // Tag each read with its issuer so the return lands there even if ownership has moved
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) rd_tag <= IDLE;
        else            rd_tag <= (mem_cs && !mem_write) ? owner : IDLE;
    end

    // Per-port holds keep the last returned word stable between reads
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            hold_add <= '0;
            hold_age <= '0;
        end else begin
            if (rd_tag == ADD) hold_add <= mem_read_data;
            if (rd_tag == AGE) hold_age <= mem_read_data;
        end
    end

    assign mem_read_data_add = (rd_tag == ADD) ? mem_read_data : hold_add;
    assign mem_read_data_age = (rd_tag == AGE) ? mem_read_data : hold_age;

`ifdef ALUT_ARB_CONFLICT_CNT_EN
    // Count cycles where the non-owner is left waiting, saturating at all-ones
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset)
            arb_conflict_cnt <= '0;
        else if (((owner == ADD && age_check_active) || (owner == AGE && add_check_active)) &&
                 arb_conflict_cnt != 16'hffff)
            arb_conflict_cnt <= arb_conflict_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_alut_mem_arbiter.sv
// tb_alut_mem_arbiter: directed bench for alut_mem_arbiter with a behavioural 256x83 memory.
module tb_alut_mem_arbiter;
    localparam logic [82:0] W5  = {1'b1, 32'h0, 2'b01, 48'h0011_2233_4455};
    localparam logic [82:0] W10 = {1'b1, 32'h0, 2'b10, 48'hAABB_CCDD_EEFF};
    localparam logic [82:0] W20 = {1'b1, 32'h0, 2'b11, 48'h1234_5678_9ABC};
    localparam logic [82:0] W30 = {1'b1, 32'h5, 2'b00, 48'h0F0F_F0F0_1357};

    logic        pclk = 1'b0;
    logic        n_p_reset;
    logic        add_check_active, mem_write_add, age_check_active, mem_write_age;
    logic [7:0]  mem_addr_add, mem_addr_age, mem_addr;
    logic [82:0] mem_write_data_add, mem_write_data_age, mem_write_data;
    logic [82:0] mem_read_data = '0;
    logic [82:0] mem_read_data_add, mem_read_data_age;
    logic        mem_cs, mem_write, grant_add, grant_age;
    logic [82:0] mem [256];
    int          checks = 0;
    int          errors = 0;
`ifdef ALUT_ARB_CONFLICT_CNT_EN
    logic [15:0] cnt;
`endif

    alut_mem_arbiter dut (
        .pclk(pclk), .n_p_reset(n_p_reset),
        .add_check_active(add_check_active), .mem_addr_add(mem_addr_add),
        .mem_write_add(mem_write_add), .mem_write_data_add(mem_write_data_add),
        .age_check_active(age_check_active), .mem_addr_age(mem_addr_age),
        .mem_write_age(mem_write_age), .mem_write_data_age(mem_write_data_age),
        .mem_read_data(mem_read_data), .mem_cs(mem_cs), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_read_data_add(mem_read_data_add), .mem_read_data_age(mem_read_data_age),
`ifdef ALUT_ARB_CONFLICT_CNT_EN
        .arb_conflict_cnt(cnt),
`endif
        .grant_add(grant_add), .grant_age(grant_age)
    );

    always #5 pclk = ~pclk;

    // Single-port memory: write on cs&write, registered read data one cycle after a read
    always @(posedge pclk) begin
        if (mem_cs && mem_write) mem[mem_addr] <= mem_write_data;
        if (mem_cs && !mem_write) mem_read_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [82:0] obs, input logic [82:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h05] = W5;
        mem[8'h10] = W10;
        mem[8'h20] = W20;
        mem[8'hff] = W5;
        n_p_reset = 1'b0;
        add_check_active = 0; mem_addr_add = 0; mem_write_add = 0; mem_write_data_add = '0;
        age_check_active = 0; mem_addr_age = 0; mem_write_age = 0; mem_write_data_age = '0;
        #2;
        chk("rst_cs", mem_cs, 0);
        chk("rst_gadd", grant_add, 0);
        chk("rst_gage", grant_age, 0);
        chk("rst_rd_add", mem_read_data_add, 0);
        chk("rst_rd_age", mem_read_data_age, 0);
`ifdef ALUT_ARB_CONFLICT_CNT_EN
        chk("rst_cnt", cnt, 0);
`endif
        tick(); tick();
        n_p_reset = 1'b1;
        tick();
        chk("idle_cs", mem_cs, 0);
        chk("idle_gage", grant_age, 0);

        // Age read of address 5
        age_check_active = 1; mem_addr_age = 8'h05;
        tick();
        chk("age_grant", grant_age, 1);
        chk("age_gadd", grant_add, 0);
        chk("age_cs", mem_cs, 1);
        chk("age_addr", mem_addr, 8'h05);
        chk("age_we", mem_write, 0);
        tick();
        chk("age_rd", mem_read_data_age, W5);
        chk("age_rd_add_unch", mem_read_data_add, 0);
        age_check_active = 0;
        tick();
        chk("age_rel_grant", grant_age, 0);
        chk("age_rel_cs", mem_cs, 0);
        chk("age_rel_rd", mem_read_data_age, W5);
        tick();
        chk("age_hold", mem_read_data_age, W5);

        // Simultaneous request: add wins, age waits
        add_check_active = 1; mem_addr_add = 8'h20;
        age_check_active = 1; mem_addr_age = 8'h10;
        tick();
        chk("both_gadd", grant_add, 1);
        chk("both_gage", grant_age, 0);
        chk("both_addr", mem_addr, 8'h20);
        tick();
        chk("add_rd", mem_read_data_add, W20);
        chk("add_rd_age_unch", mem_read_data_age, W5);
        chk("age_wait", grant_age, 0);
        tick();
        add_check_active = 0;
        tick();
        chk("hand_gage", grant_age, 1);
        chk("hand_gadd", grant_add, 0);
        chk("hand_addr", mem_addr, 8'h10);
`ifdef ALUT_ARB_CONFLICT_CNT_EN
        chk("cnt_wait", cnt, 3);
`endif

        // Age writes 0xff while releasing, add waiting
        mem_addr_age = 8'hff; mem_write_age = 1; mem_write_data_age = '0; age_check_active = 0;
        add_check_active = 1; mem_addr_add = 8'h20;
        #1;
        chk("wr_cs", mem_cs, 1);
        chk("wr_we", mem_write, 1);
        chk("wr_addr", mem_addr, 8'hff);
        chk("wr_data", mem_write_data, 0);
        tick();
        chk("wr_gadd", grant_add, 1);
        chk("wr_gage", grant_age, 0);
        chk("wr_mem", mem[8'hff], 0);
        chk("wr_age_hold", mem_read_data_age, W5);
        chk("wr_add_hold", mem_read_data_add, W20);
`ifdef ALUT_ARB_CONFLICT_CNT_EN
        chk("cnt_wr", cnt, 4);
`endif

        // Age reads 0x10 and releases while add takes over with a write
        add_check_active = 0; age_check_active = 1;
        mem_addr_age = 8'h10; mem_write_age = 0;
        tick();
        chk("rr_gage", grant_age, 1);
        age_check_active = 0; add_check_active = 1;
        mem_addr_add = 8'h30; mem_write_add = 1; mem_write_data_add = W30;
        tick();
        chk("rr_gadd", grant_add, 1);
        chk("rr_gage", grant_age, 0);
        chk("rr_age_rd", mem_read_data_age, W10);
        chk("rr_add_hold", mem_read_data_add, W20);
`ifdef ALUT_ARB_CONFLICT_CNT_EN
        chk("cnt_rr", cnt, 6);
`endif
        add_check_active = 0;
        tick();
        chk("rr_age_hold", mem_read_data_age, W10);
        chk("rr_add_hold2", mem_read_data_add, W20);
        chk("rr_mem30", mem[8'h30], W30);
        chk("rr_idle", mem_cs, 0);

        // Reset while add owns memory with a read in flight
        add_check_active = 1; mem_addr_add = 8'h05; mem_write_add = 0;
        tick();
        chk("pre_rst_gadd", grant_add, 1);
        #2;
        n_p_reset = 0;
        #1;
        chk("arst_cs", mem_cs, 0);
        chk("arst_gadd", grant_add, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_rd_add", mem_read_data_add, 0);
        chk("arst_rd_age", mem_read_data_age, 0);
`ifdef ALUT_ARB_CONFLICT_CNT_EN
        chk("arst_cnt", cnt, 0);
`endif
        add_check_active = 0;
        tick();
        n_p_reset = 1;
        tick();
        chk("post_cs", mem_cs, 0);
        chk("post_gadd", grant_add, 0);
        chk("post_gage", grant_age, 0);
        chk("post_rd_add", mem_read_data_add, 0);
        chk("post_rd_age", mem_read_data_age, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alut_mem_arbiter.md
Name: alut_mem_arbiter

Overview:
- Arbitrates the single-port 256x83 ALUT memory between two requesters: the address checker (add port) and the age checker (age port).
- Sits directly downstream of the age checker's memory bus (mem_addr/mem_write/mem_write_data) and upstream of its mem_read_data input.
- Owner-hold arbitration: the granted requester keeps the memory while its active flag is high. Read data is steered back to the requester that issued the read, and that port holds it stable.

Parameters:
- ADDR_W, 8, memory address width (256 entries)
- DATA_W, 83, memory word width ([82]=valid, [49:48]=port, [47:0]=MAC address)

Ports:
- pclk  in  1  APB clock
- n_p_reset  in  1  asynchronous active-low reset
- add_check_active  in  1  address checker requests/holds memory
- mem_addr_add  in  ADDR_W  address checker address
- mem_write_add  in  1  address checker write (1=write)
- mem_write_data_add  in  DATA_W  address checker write data
- age_check_active  in  1  age checker requests/holds memory
- mem_addr_age  in  ADDR_W  age checker address
- mem_write_age  in  1  age checker write
- mem_write_data_age  in  DATA_W  age checker write data
- mem_read_data  in  DATA_W  memory read data, valid 1 cycle after read
- mem_cs  out  1  memory chip select
- mem_addr  out  ADDR_W  memory address
- mem_write  out  1  memory write enable
- mem_write_data  out  DATA_W  memory write data
- mem_read_data_add  out  DATA_W  read data to address checker
- mem_read_data_age  out  DATA_W  read data to age checker
- grant_add  out  1  address checker owns memory
- grant_age  out  1  age checker owns memory

Behaviour:
- Reset: owner=IDLE; mem_cs=0, mem_addr=0, mem_write=0, mem_write_data=0; both read-data holds=0; grant_add=grant_age=0; rd_tag=NONE.
- Owner FSM, registered, states IDLE/ADD/AGE. Next-state rules:
  - IDLE: add_check_active -> ADD; else age_check_active -> AGE; else IDLE. Add wins a simultaneous request.
  - ADD: add_check_active=1 -> ADD. If 0: age_check_active -> AGE, else IDLE. No dead cycle on handover.
  - AGE: age_check_active=1 -> AGE. If 0: add_check_active -> ADD, else IDLE.
  - The owner is never pre-empted. A waiting requester stalls until the owner releases.
- Grant latency: 1 cycle from the active flag rising to the grant. A requester's bus is ignored until its grant is high.
- Memory bus is a combinational mux on the registered owner:
  - ADD: mem_cs=1, bus = add port signals.
  - AGE: mem_cs=1, bus = age port signals.
  - IDLE: mem_cs=0, mem_write=0, addr/data=0.
- grant_add = (owner==ADD); grant_age = (owner==AGE).
- Read return:
  - rd_tag is registered: set to the owner when mem_cs & ~mem_write, else NONE.
  - mem_read_data_add = mem_read_data when rd_tag==ADD, else hold_add. hold_add captures mem_read_data whenever rd_tag==ADD. The age port works the same way with AGE/hold_age.
  - Read latency to a port is exactly 1 cycle. The non-tagged port's output is unchanged.
- Owner release in the same cycle as a read: data still returns to the issuing port on the next cycle, even though ownership has moved.
- Writes have no return. The port hold value is unchanged across writes.
- Asynchronous reset mid-operation: returns everything to the reset values immediately. Any pending read return is discarded.

Optional Feature:
- Macro ALUT_ARB_CONFLICT_CNT_EN.
- Defined:
  - Adds output arb_conflict_cnt, 16 bits.
  - Increments each cycle the owner is ADD or AGE while the other port's active flag is high.
  - Saturates at 16'hffff.
  - Reset value 0.
- Undefined: the port and counter are absent. Arbitration behaviour is identical.

Test Plan:
- Reset, both active=0 -> mem_cs=0, grants=0, both read outputs=0.
- age_check_active=1, mem_addr_age=8'h05, read; memory word 5 = {1'b1,...,48'h0011_2233_4455} -> grant_age=1 next cycle. mem_read_data_age=that word 1 cycle after mem_cs. mem_read_data_add unchanged.
- add_check_active and age_check_active rise together -> grant_add=1. Age waits until add drops, then grant_age=1 in the very next cycle. With macro: counter counts the waiting cycles exactly.
- Age owner in inval-all writes address 8'hff, data=0, then drops active while add is active -> write reaches memory with mem_write=1. Ownership moves to ADD next cycle; no IDLE gap.
- Age reads addr 8'h10, then releases; add is granted the same edge -> read data lands on the age port only; hold_add is unaffected.
- n_p_reset asserted while owner=ADD with a pending read -> all outputs 0 immediately. After release the FSM is IDLE and no stale data appears.
